sa_banked_scratchpad: RTL and testbench

//   Parametrised, banked scratchpad serving the systolic array's per-lane operand fetch (x/w) and

---
 rtl/sa_banked_scratchpad.sv | 193 +++++++++++++++++++
 tb/tb_sa_banked_scratchpad.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_banked_scratchpad.sv
// Banked 1R1W scratchpad for systolic-array operand fetch and result write-back.
// Each bank has its own round-robin arbiter per direction; losing requesters
// see ready=0 and hold. Out-of-range accesses bypass the banks entirely.

// Round-robin arbiter: scans from the pointer, pointer moves past the winner.
module sa_banked_scratchpad_rr #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic          hit;

  // First requester at or after the pointer, wrapping around
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!hit && req_i[j]) begin
        hit   = 1'b1;
        idx_o = IW'(j);
      end
    end
    if (hit) gnt_o[idx_o] = 1'b1;
  end

  // Pointer advances to winner+1; idle cycles leave it alone
  always_comb begin
    ptr_d = ptr_q;
    if (hit) ptr_d = (idx_o == IW'(N-1)) ? '0 : idx_o + 1'b1;
  end

  // Pointer register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

module sa_banked_scratchpad #(
  parameter int RD_PORTS = 128,
  parameter int WR_PORTS = 64,
  parameter int BANKS    = 16,
  parameter int DEPTH    = 1024,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 2
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic [RD_PORTS-1:0]                rd_req,
  input  logic [RD_PORTS-1:0][ADDR_W-1:0]    rd_addr,
  output logic [RD_PORTS-1:0]                rd_ready,
  output logic [RD_PORTS-1:0]                rd_rvalid,
  output logic [RD_PORTS-1:0][DATA_W-1:0]    rd_rdata,
  input  logic [WR_PORTS-1:0]                wr_req,
  input  logic [WR_PORTS-1:0][ADDR_W-1:0]    wr_addr,
  input  logic [WR_PORTS-1:0][DATA_W-1:0]    wr_data,
  output logic [WR_PORTS-1:0]                wr_ready,
  output logic                               oob_err,
  output logic [31:0]                        stall_cnt
);
  localparam int BB  = $clog2(BANKS);
  localparam int RB  = $clog2(DEPTH);
  localparam int RIW = $clog2(RD_PORTS);
  localparam int WIW = $clog2(WR_PORTS);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(BANKS * DEPTH);

  logic [DATA_W-1:0] mem_q [BANKS][DEPTH];

  logic [RD_PORTS-1:0] rd_inr, rd_xfer;
  logic [WR_PORTS-1:0] wr_inr, wr_xfer;
  logic [RD_PORTS-1:0] rd_bgnt [BANKS];
  logic [WR_PORTS-1:0] wr_bgnt [BANKS];
  logic [RIW-1:0]      rd_bidx [BANKS];
  logic [WIW-1:0]      wr_bidx [BANKS];
  logic [RB-1:0]       rd_brow [BANKS];
  logic [RB-1:0]       wr_brow [BANKS];
  logic [DATA_W-1:0]   wr_bdata[BANKS];
  logic [BANKS-1:0]    wr_bwe;

  logic [RD_PORTS-1:0][DATA_W-1:0] rd_pdata;
  logic [RD_LAT-1:0][RD_PORTS-1:0]             vld_pipe_q;
  logic [RD_LAT-1:0][RD_PORTS-1:0][DATA_W-1:0] dat_pipe_q;

  logic        oob_seen, refused;
  logic        oob_err_q, oob_err_d;
  logic [31:0] stall_q, stall_d;

  // Range check per port
  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) rd_inr[i] = rd_addr[i] < LIMIT;
    for (int i = 0; i < WR_PORTS; i++) wr_inr[i] = wr_addr[i] < LIMIT;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [RD_PORTS-1:0] rd_breq;
    logic [WR_PORTS-1:0] wr_breq;

    // Route each in-range request to the bank its low address bits select
    always_comb begin
      for (int i = 0; i < RD_PORTS; i++)
        rd_breq[i] = rd_req[i] & rd_inr[i] & (rd_addr[i][BB-1:0] == BB'(b));
      for (int i = 0; i < WR_PORTS; i++)
        wr_breq[i] = wr_req[i] & wr_inr[i] & (wr_addr[i][BB-1:0] == BB'(b));
    end

    sa_banked_scratchpad_rr #(.N(RD_PORTS)) u_rd_arb (
      .clk(clk), .n_rst(n_rst), .req_i(rd_breq), .gnt_o(rd_bgnt[b]), .idx_o(rd_bidx[b])
    );
    sa_banked_scratchpad_rr #(.N(WR_PORTS)) u_wr_arb (
      .clk(clk), .n_rst(n_rst), .req_i(wr_breq), .gnt_o(wr_bgnt[b]), .idx_o(wr_bidx[b])
    );

    assign rd_brow[b]  = rd_addr[rd_bidx[b]][BB +: RB];
    assign wr_brow[b]  = wr_addr[wr_bidx[b]][BB +: RB];
    assign wr_bdata[b] = wr_data[wr_bidx[b]];
    assign wr_bwe[b]   = n_rst & (|wr_bgnt[b]);
  end

  // Ready: out-of-range always passes, in-range needs its bank's grant
  always_comb begin
    for (int i = 0; i < RD_PORTS; i++)
      rd_ready[i] = n_rst & rd_req[i] & (~rd_inr[i] | rd_bgnt[rd_addr[i][BB-1:0]][i]);
    for (int i = 0; i < WR_PORTS; i++)
      wr_ready[i] = n_rst & wr_req[i] & (~wr_inr[i] | wr_bgnt[wr_addr[i][BB-1:0]][i]);
    rd_xfer = rd_req & rd_ready;
    wr_xfer = wr_req & wr_ready;
    refused = (|(rd_req & ~rd_ready)) | (|(wr_req & ~wr_ready));
    oob_seen = (|(rd_xfer & ~rd_inr)) | (|(wr_xfer & ~wr_inr));
  end

  // Bank read port data (the bank's single read address is the winner's row)
  always_comb begin
    for (int i = 0; i < RD_PORTS; i++)
      rd_pdata[i] = rd_inr[i] ? mem_q[rd_addr[i][BB-1:0]][rd_brow[rd_addr[i][BB-1:0]]] : '0;
  end

  // SRAM write; not reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++)
      if (wr_bwe[b]) mem_q[b][wr_brow[b]] <= wr_bdata[b];
  end

  // Read latency pipeline; data stages only load behind a valid so the tail holds
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= rd_xfer;
      for (int i = 0; i < RD_PORTS; i++)
        if (rd_xfer[i]) dat_pipe_q[0][i] <= rd_pdata[i];
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        for (int i = 0; i < RD_PORTS; i++)
          if (vld_pipe_q[s-1][i]) dat_pipe_q[s][i] <= dat_pipe_q[s-1][i];
      end
    end
  end

  // Sticky OOB flag and saturating stall counter
  always_comb begin
    oob_err_d = oob_err_q | oob_seen;
    stall_d   = (refused && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
  end

  // Status registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      oob_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      oob_err_q <= oob_err_d;
      stall_q   <= stall_d;
    end
  end

  assign rd_rvalid = vld_pipe_q[RD_LAT-1];
  assign rd_rdata  = dat_pipe_q[RD_LAT-1];
  assign oob_err   = oob_err_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_sa_banked_scratchpad.sv
// Bench for sa_banked_scratchpad: directed table + hand sequences, then a
// randomized run against a per-bank round-robin reference model.
module tb_sa_banked_scratchpad;
  localparam int RD = 128, WR = 64, BANKS = 16, DEPTH = 1024, DW = 32, AW = 32, LAT = 2;
  localparam int LIM = BANKS * DEPTH;

  logic clk, n_rst;
  logic [RD-1:0]         rd_req, rd_ready, rd_rvalid;
  logic [RD-1:0][AW-1:0] rd_addr;
  logic [RD-1:0][DW-1:0] rd_rdata;
  logic [WR-1:0]         wr_req, wr_ready;
  logic [WR-1:0][AW-1:0] wr_addr;
  logic [WR-1:0][DW-1:0] wr_data;
  logic                  oob_err;
  logic [31:0]           stall_cnt;

  sa_banked_scratchpad #(.RD_PORTS(RD), .WR_PORTS(WR), .BANKS(BANKS), .DEPTH(DEPTH),
                         .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .n_rst(n_rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .oob_err(oob_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] f32(input int n);
    int e;
    e = 0;
    while ((1 << (e + 1)) <= n) e++;
    return {1'b0, 8'(e + 127), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  task automatic clear_in();
    rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); n_rst = 1'b0; clear_in();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  // ---------------- reference model ----------------
  bit          prd [RD];
  logic [31:0] prd_a [RD];
  bit          pwr [WR];
  logic [31:0] pwr_a [WR], pwr_d [WR];
  int          rptr [BANKS], wptr [BANKS];
  logic [31:0] mdl [LIM];
  logic [RD-1:0] fut_v [8];
  logic [31:0] fut_d [8][RD];
  logic [31:0] hold [RD];
  bit          m_oob, gen;
  logic [31:0] m_stall;
  int          cyc;

  task automatic model_init();
    for (int i = 0; i < RD; i++) begin prd[i] = 0; hold[i] = '0; end
    for (int i = 0; i < WR; i++) pwr[i] = 0;
    for (int b = 0; b < BANKS; b++) begin rptr[b] = 0; wptr[b] = 0; end
    for (int s = 0; s < 8; s++) fut_v[s] = '0;
    m_oob = 0; m_stall = '0; cyc = 0; gen = 0;
  endtask

  function automatic bit pending_any();
    bit p;
    p = 0;
    for (int i = 0; i < RD; i++) p |= prd[i];
    for (int i = 0; i < WR; i++) p |= pwr[i];
    return p;
  endfunction

  task automatic step();
    logic [RD-1:0] erd;
    logic [WR-1:0] ewr;
    int s, j, bad;
    bit stall;
    @(negedge clk);
    if (gen) begin
      for (int i = 0; i < RD; i++)
        if (!prd[i] && $urandom_range(0, 3) == 0) begin
          prd[i] = 1;
          prd_a[i] = ($urandom_range(0, 31) == 0) ? 32'(LIM + $urandom_range(0, 999))
                                                  : 32'($urandom_range(0, 63));
        end
      for (int i = 0; i < WR; i++)
        if (!pwr[i] && $urandom_range(0, 7) == 0) begin
          pwr[i] = 1;
          pwr_a[i] = ($urandom_range(0, 31) == 0) ? 32'(LIM + $urandom_range(0, 999))
                                                  : 32'($urandom_range(0, 63));
          pwr_d[i] = $urandom;
        end
    end
    for (int i = 0; i < RD; i++) begin rd_req[i] = prd[i]; rd_addr[i] = prd_a[i]; end
    for (int i = 0; i < WR; i++) begin
      wr_req[i] = pwr[i]; wr_addr[i] = pwr_a[i]; wr_data[i] = pwr_d[i];
    end
    #1;
    // expected grants: OOB always, else one winner per bank from the RR pointer
    erd = '0; ewr = '0;
    for (int i = 0; i < RD; i++) if (prd[i] && prd_a[i] >= LIM) erd[i] = 1'b1;
    for (int i = 0; i < WR; i++) if (pwr[i] && pwr_a[i] >= LIM) ewr[i] = 1'b1;
    for (int b = 0; b < BANKS; b++) begin
      for (int k = 0; k < RD; k++) begin
        j = (rptr[b] + k) % RD;
        if (prd[j] && prd_a[j] < LIM && prd_a[j] % BANKS == b) begin
          erd[j] = 1'b1; rptr[b] = (j + 1) % RD; break;
        end
      end
      for (int k = 0; k < WR; k++) begin
        j = (wptr[b] + k) % WR;
        if (pwr[j] && pwr_a[j] < LIM && pwr_a[j] % BANKS == b) begin
          ewr[j] = 1'b1; wptr[b] = (j + 1) % WR; break;
        end
      end
    end
    chk("rnd_rd_ready", rd_ready, erd);
    chk("rnd_wr_ready", wr_ready, ewr);
    s = cyc % 8;
    for (int i = 0; i < RD; i++) if (fut_v[s][i]) hold[i] = fut_d[s][i];
    chk("rnd_rvalid", rd_rvalid, fut_v[s]);
    fut_v[s] = '0;
    bad = -1;
    for (int i = 0; i < RD; i++) if (bad < 0 && rd_rdata[i] !== hold[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL rnd_rdata port %0d: got %h expected %h", bad, rd_rdata[bad], hold[bad]);
    end
    chk("rnd_oob_err", oob_err, m_oob);
    chk("rnd_stall_cnt", stall_cnt, m_stall);
    // commit this cycle's transfers
    stall = 0;
    for (int i = 0; i < RD; i++) begin
      if (prd[i] && !erd[i]) stall = 1;
      if (erd[i]) begin
        fut_v[(cyc + LAT) % 8][i] = 1'b1;
        fut_d[(cyc + LAT) % 8][i] = (prd_a[i] < LIM) ? mdl[prd_a[i]] : '0;
        if (prd_a[i] >= LIM) m_oob = 1;
        prd[i] = 0;
      end
    end
    for (int i = 0; i < WR; i++) begin
      if (pwr[i] && !ewr[i]) stall = 1;
      if (ewr[i]) begin
        if (pwr_a[i] < LIM) mdl[pwr_a[i]] = pwr_d[i];
        else m_oob = 1;
        pwr[i] = 0;
      end
    end
    if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    cyc++;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wen;
    logic [31:0] waddr, wdata;
    bit          ren;
    logic [31:0] raddr, exp_rdata;
    bit          exp_oob;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [RD-1:0] exp_r;
    int ord [6];
    tbl[0] = '{1, 32'h5,        f32(7),       0, 32'h0,        32'h0,        0};
    tbl[1] = '{1, 32'h5,        f32(9),       1, 32'h5,        f32(7),       0};
    tbl[2] = '{0, 32'h0,        32'h0,        1, 32'h5,        f32(9),       0};
    tbl[3] = '{1, 32'h4000,     32'hDEADBEEF, 0, 32'h0,        32'h0,        1};
    tbl[4] = '{0, 32'h0,        32'h0,        1, 32'h4000,     32'h0,        1};
    tbl[5] = '{1, 32'h3FFF,     32'h12345678, 0, 32'h0,        32'h0,        1};
    tbl[6] = '{0, 32'h0,        32'h0,        1, 32'h3FFF,     32'h12345678, 1};
    tbl[7] = '{0, 32'h0,        32'h0,        1, 32'hFFFFFFFF, 32'h0,        1};
    ord = '{0, 1, 2, 3, 5, 1};

    // 1: reset with random requests present
    n_rst = 1'b0;
    clear_in();
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < RD; i++) begin rd_req[i] = 1'($urandom); rd_addr[i] = $urandom_range(0, 70000); end
      for (int i = 0; i < WR; i++) begin wr_req[i] = 1'($urandom); wr_addr[i] = $urandom_range(0, 70000); end
      #1;
      chk("rst_rd_ready", rd_ready, '0);
      chk("rst_wr_ready", wr_ready, '0);
    end
    chk("rst_rvalid", rd_rvalid, '0);
    chk("rst_rdata", |rd_rdata, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk); clear_in(); n_rst = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk); #1;
      chk("post_rst_rvalid", rd_rvalid, '0);
    end

    // 3: three-way conflict in bank 0, then a second one from pointer 3
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin rd_req[ord[g*3+k]] = 1'b1; rd_addr[ord[g*3+k]] = 32'h20; end
      if (g == 1) begin ord[3] = 3; ord[4] = 5; ord[5] = 1; end
      for (int k = 0; k < 3; k++) begin
        #1;
        exp_r = '0; exp_r[ord[g*3+k]] = 1'b1;
        chk("conflict_grant", rd_ready, exp_r);
        @(negedge clk);
        rd_req[ord[g*3+k]] = 1'b0;
      end
      #1;
      chk("conflict_stall", stall_cnt, 32'(2 * (g + 1)));
    end
    clear_in();
    repeat (LAT + 2) @(negedge clk);

    // 2: conflict-free write of ports 0..15, then read back
    for (int i = 0; i < 16; i++) begin wr_req[i] = 1'b1; wr_addr[i] = 32'(i); wr_data[i] = f32(i + 1); end
    #1; chk("cf_wr_ready", wr_ready, 64'hFFFF);
    @(negedge clk); clear_in();
    for (int i = 0; i < 16; i++) begin rd_req[i] = 1'b1; rd_addr[i] = 32'(i); end
    #1; chk("cf_rd_ready", rd_ready, 128'hFFFF);
    @(negedge clk); clear_in();
    @(negedge clk); #1;
    chk("cf_rvalid", rd_rvalid, 128'hFFFF);
    for (int i = 0; i < 16; i++) chk("cf_rdata", rd_rdata[i], f32(i + 1));
    @(negedge clk); #1;
    chk("cf_rvalid_one_cycle", rd_rvalid, '0);

    // table: RAW, OOB, top-of-range
    foreach (tbl[t]) begin
      @(negedge clk);
      wr_req[0] = tbl[t].wen; wr_addr[0] = tbl[t].waddr; wr_data[0] = tbl[t].wdata;
      rd_req[0] = tbl[t].ren; rd_addr[0] = tbl[t].raddr;
      #1;
      chk("tbl_wr_ready", wr_ready[0], tbl[t].wen);
      chk("tbl_rd_ready", rd_ready[0], tbl[t].ren);
      @(negedge clk); clear_in();
      @(negedge clk); #1;
      chk("tbl_rvalid", rd_rvalid[0], tbl[t].ren);
      if (tbl[t].ren) chk("tbl_rdata", rd_rdata[0], tbl[t].exp_rdata);
      chk("tbl_oob", oob_err, tbl[t].exp_oob);
    end

    // 6: reset while a read is in flight
    @(negedge clk);
    rd_req[0] = 1'b1; rd_addr[0] = 32'h5;
    #1; chk("mid_rd_ready", rd_ready[0], 1);
    @(negedge clk); clear_in(); n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (LAT + 3) begin
      @(negedge clk); #1;
      chk("mid_no_rvalid", rd_rvalid, '0);
    end
    chk("mid_oob_cleared", oob_err, 0);
    rd_req[0] = 1'b1; rd_addr[0] = 32'h5;
    @(negedge clk); clear_in();
    @(negedge clk); #1;
    chk("mid_retained_rvalid", rd_rvalid[0], 1);
    chk("mid_retained_rdata", rd_rdata[0], f32(9));

    // randomized run against the model
    do_reset();
    model_init();
    for (int i = 0; i < WR; i++) begin pwr[i] = 1; pwr_a[i] = 32'(i); pwr_d[i] = $urandom; end
    for (int c = 0; c < 100 && pending_any(); c++) step();
    chk("fill_drained", pending_any(), 0);
    gen = 1;
    repeat (300) step();
    gen = 0;
    for (int c = 0; c < 400 && pending_any(); c++) step();
    chk("rnd_drained", pending_any(), 0);
    repeat (LAT + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
